// File: rtl/rx_ocp_pkg.sv
// rx_ocp_pkg: encodings shared by the Rx TLP-to-OCP translator and the Rx
// header/data FSM. It holds the OCP MCmd values, the ocp_reg_ctl slice
// steering codes, the translator state set and the TLP header field positions
// within a 64-bit Rx beat. Beat layout: DW0 is in [31:0] and DW1 in [63:32].
package rx_ocp_pkg;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2
  } mcmd_e;

  typedef enum logic [2:0] {
    CTL_IDLE  = 3'd0,
    CTL_H1    = 3'd1,
    CTL_H2    = 3'd2,
    CTL_DATA3 = 3'd3,
    CTL_DATA4 = 3'd4
  } reg_ctl_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_WR_STREAM,
    ST_DRAIN
  } xlate_state_e;

  // Field positions within the H1 beat.
  localparam int unsigned FMT_HI  = 30;
  localparam int unsigned FMT_LO  = 29;
  localparam int unsigned TYPE_HI = 28;
  localparam int unsigned TYPE_LO = 24;
  localparam int unsigned LEN_HI  = 9;
  localparam int unsigned LEN_LO  = 0;
  localparam int unsigned FBE_HI  = 35;
  localparam int unsigned FBE_LO  = 32;
  localparam int unsigned LBE_HI  = 39;
  localparam int unsigned LBE_LO  = 36;

  localparam int unsigned BUF_DEPTH = 3;

  // A length field of 0 encodes 1024 DWs.
  function automatic logic [10:0] decode_len(input logic [9:0] f);
    return {(f == 10'd0), f};
  endfunction

endpackage

// File: rtl/rx_dw_buffer.sv
// rx_dw_buffer: 3-entry x 32-bit DW FIFO sitting between the Rx data beats
// and the OCP write stream.
//   clk, reset          : clock, synchronous active-high reset
//   push_cnt            : number of DWs to push this cycle (0..2)
//   push_dw0, push_dw1  : DWs to push, in order
//   pop                 : drop the head entry (ignored when empty)
//   count               : current occupancy
//   count_nxt, head_nxt : occupancy and head entry after this cycle's update,
//                         so the consumer can register its outputs from them
module rx_dw_buffer
  import rx_ocp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  push_cnt,
  input  logic [31:0] push_dw0,
  input  logic [31:0] push_dw1,
  input  logic        pop,
  output logic [1:0]  count,
  output logic [1:0]  count_nxt,
  output logic [31:0] head_nxt
);

  logic [31:0] mem     [BUF_DEPTH];
  logic [31:0] mem_nxt [BUF_DEPTH];
  logic [1:0]  base;
  logic [2:0]  sum;

  // Entry 0 is always the head. A pop shifts everything down one slot, and
  // pushes then land directly above whatever remains.
  always_comb begin
    mem_nxt = mem;
    base    = count;
    if (pop && (count != 2'd0)) begin
      for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
        mem_nxt[i] = mem[i+1];
      end
      base = count - 2'd1;
    end
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      if ((push_cnt != 2'd0) && ({1'b0, base} == 3'(i))) begin
        mem_nxt[i] = push_dw0;
      end
      if ((push_cnt == 2'd2) && (({1'b0, base} + 3'd1) == 3'(i))) begin
        mem_nxt[i] = push_dw1;
      end
    end
    sum       = {1'b0, base} + {1'b0, push_cnt};
    count_nxt = (sum > 3'd3) ? 2'd3 : sum[1:0];
    head_nxt  = mem_nxt[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      mem   <= mem_nxt;
    end
  end

endmodule

// File: rtl/rx_ocp_xlate.sv
// rx_ocp_xlate: turns Rx AXI TLP beats, steered by the Rx FSM through
// ocp_reg_ctl, into OCP master requests. A memory read becomes a single
// burst RD. A memory write becomes a stream of single-DW WRs fed through a
// 3-entry DW buffer.
//   rx_clk, rx_reset        : clock, synchronous active-high reset
//   rx_data/keep/valid/last : Rx AXI beat from the PCIe core
//   rx_ready                : AXI ready as driven by the Rx FSM (observed)
//   ocp_reg_ctl             : beat steering (IDLE/H1/H2/DATA3/DATA4)
//   optype                  : {has_data, hdr4dw} of the current TLP
//   ocp_ready               : buffer can take a full 2-DW beat
//   ocp_m*                  : OCP request (all registered)
//   ocp_scmdaccept          : slave accepts the current command
// Optional: define RX_OCP_XLATE_ERR_EN to add the sticky xlate_err output.
// Non-MRd/MWr TLPs then issue no commands and are drained, and an extra DATA
// beat after length DWs also sets xlate_err.
module rx_ocp_xlate
  import rx_ocp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [KEEP_WIDTH-1:0] rx_keep,
  input  logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic                  rx_last,
  input  logic [2:0]            ocp_reg_ctl,
  output logic [1:0]            optype,
  output logic                  ocp_ready,
  output logic [2:0]            ocp_mcmd,
  output logic [ADDR_WIDTH-1:0] ocp_maddr,
  output logic [31:0]           ocp_mdata,
  output logic [3:0]            ocp_mbyteen,
  output logic [10:0]           ocp_mburstlength,
  input  logic                  ocp_scmdaccept
`ifdef RX_OCP_XLATE_ERR_EN
  ,
  output logic                  xlate_err
`endif
);

  xlate_state_e          state;
  logic [10:0]           length;
  logic [10:0]           issued;
  logic [10:0]           pushed;
  logic [3:0]            first_be;
  logic [3:0]            last_be;
  logic [ADDR_WIDTH-1:0] addr;

  logic                  beat;
  logic                  h1_take;
  logic                  h2_take;
  logic                  data_take;
  logic                  pop;
  logic                  last_pop;
  logic                  wr_next;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [1:0]            push_cnt;
  logic [31:0]           push_dw0;
  logic [31:0]           push_dw1;
  logic [10:0]           issued_nxt;
  logic [3:0]            be_nxt;
  logic [1:0]            buf_count;
  logic [1:0]            buf_count_nxt;
  logic [31:0]           buf_head_nxt;

  // rx_keep[3:0] is implied by any taken beat. rx_last only matters when
  // draining unsupported TLPs.
  logic unused_inputs;
`ifdef RX_OCP_XLATE_ERR_EN
  assign unused_inputs = ^rx_keep[3:0];
`else
  assign unused_inputs = ^{rx_keep[3:0], rx_last};
`endif

  always_comb begin
    beat      = rx_valid && rx_ready;
    h1_take   = beat && (ocp_reg_ctl == CTL_H1) && (state == ST_IDLE);
    h2_take   = beat && (ocp_reg_ctl == CTL_H2) && (state == ST_HDR);
    data_take = beat && ((ocp_reg_ctl == CTL_DATA3) || (ocp_reg_ctl == CTL_DATA4))
                && (state == ST_WR_STREAM);

    hdr_addr  = optype[0] ? ADDR_WIDTH'({rx_data[31:0], rx_data[63:34], 2'b00})
                          : ADDR_WIDTH'({32'h0, rx_data[31:2], 2'b00});
    // On the H2 beat, addr is still being loaded, so the first write uses
    // the decoded header address directly.
    base_addr = h2_take ? hdr_addr : addr;

    push_cnt = '0;
    push_dw0 = rx_data[31:0];
    push_dw1 = rx_data[63:32];
    if (h2_take && optype[1] && !optype[0]) begin
      // A 3DW write header carries data DW 0 in its upper half.
      push_cnt = 2'd1;
      push_dw0 = rx_data[63:32];
    end else if (data_take && (pushed < length)) begin
      push_cnt = 2'd1;
      if ((rx_keep[7:4] != 4'h0) && ((pushed + 11'd1) < length)) begin
        push_cnt = 2'd2;
      end
    end

    pop        = (state == ST_WR_STREAM) && (ocp_mcmd == MCMD_WR) && ocp_scmdaccept
                 && (buf_count != 2'd0);
    issued_nxt = issued + {10'd0, pop};
    last_pop   = pop && (issued_nxt == length);
    wr_next    = (h2_take && optype[1]) || ((state == ST_WR_STREAM) && !last_pop);

    if (issued_nxt == 11'd0) begin
      be_nxt = first_be;
    end else if ((length > 11'd1) && (issued_nxt == (length - 11'd1))) begin
      be_nxt = last_be;
    end else begin
      be_nxt = 4'hF;
    end
  end

  rx_dw_buffer u_buf (
    .clk       (rx_clk),
    .reset     (rx_reset),
    .push_cnt  (push_cnt),
    .push_dw0  (push_dw0),
    .push_dw1  (push_dw1),
    .pop       (pop),
    .count     (buf_count),
    .count_nxt (buf_count_nxt),
    .head_nxt  (buf_head_nxt)
  );

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state            <= ST_IDLE;
      optype           <= '0;
      ocp_ready        <= 1'b0;
      ocp_mcmd         <= MCMD_IDLE;
      ocp_maddr        <= '0;
      ocp_mdata        <= '0;
      ocp_mbyteen      <= '0;
      ocp_mburstlength <= '0;
      length           <= '0;
      issued           <= '0;
      pushed           <= '0;
      first_be         <= '0;
      last_be          <= '0;
      addr             <= '0;
`ifdef RX_OCP_XLATE_ERR_EN
      xlate_err        <= 1'b0;
`endif
    end else begin
      pushed <= pushed + {9'd0, push_cnt};
      issued <= issued_nxt;

      // The write command is registered from the buffer's next head, so a DW
      // is presented the cycle after it is pushed and the cycle after the
      // previous one is accepted.
      if (wr_next) begin
        ocp_mcmd         <= (buf_count_nxt != 2'd0) ? MCMD_WR : MCMD_IDLE;
        ocp_maddr        <= base_addr + ADDR_WIDTH'({issued_nxt, 2'b00});
        ocp_mdata        <= buf_head_nxt;
        ocp_mbyteen      <= be_nxt;
        ocp_mburstlength <= 11'd1;
        ocp_ready        <= (buf_count_nxt <= 2'd1);
      end

      case (state)
        ST_IDLE: begin
          if (h1_take) begin
            optype   <= rx_data[FMT_HI:FMT_LO];
            length   <= decode_len(rx_data[LEN_HI:LEN_LO]);
            first_be <= rx_data[FBE_HI:FBE_LO];
            last_be  <= rx_data[LBE_HI:LBE_LO];
            issued   <= '0;
            pushed   <= '0;
`ifdef RX_OCP_XLATE_ERR_EN
            if (rx_data[TYPE_HI:TYPE_LO] != 5'd0) begin
              state     <= ST_DRAIN;
              ocp_ready <= 1'b1;
              xlate_err <= 1'b1;
            end else begin
              state <= ST_HDR;
            end
`else
            state <= ST_HDR;
`endif
          end
        end
        ST_HDR: begin
          if (h2_take) begin
            addr <= hdr_addr;
            if (optype[1]) begin
              state <= ST_WR_STREAM;
            end else begin
              state            <= ST_RD_REQ;
              ocp_mcmd         <= MCMD_RD;
              ocp_maddr        <= hdr_addr;
              ocp_mburstlength <= length;
              ocp_mbyteen      <= first_be;
            end
          end
        end
        ST_RD_REQ: begin
          if (ocp_scmdaccept) begin
            state    <= ST_IDLE;
            ocp_mcmd <= MCMD_IDLE;
          end
        end
        ST_WR_STREAM: begin
`ifdef RX_OCP_XLATE_ERR_EN
          if (data_take && (pushed >= length)) begin
            xlate_err <= 1'b1;
          end
`endif
          if (last_pop) begin
            state     <= ST_IDLE;
            ocp_mcmd  <= MCMD_IDLE;
            ocp_ready <= 1'b0;
          end
        end
`ifdef RX_OCP_XLATE_ERR_EN
        ST_DRAIN: begin
          // Keep ocp_ready high so the Rx FSM can sink the remaining beats.
          if (beat && rx_last) begin
            state     <= ST_IDLE;
            ocp_ready <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ocp_xlate.sv
module tb_rx_ocp_xlate;
  import rx_ocp_pkg::*;

  logic        clk = 1'b0;
  logic        rx_reset;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_last;
  logic [2:0]  ocp_reg_ctl;
  logic [1:0]  optype;
  logic        ocp_ready;
  logic [2:0]  ocp_mcmd;
  logic [63:0] ocp_maddr;
  logic [31:0] ocp_mdata;
  logic [3:0]  ocp_mbyteen;
  logic [10:0] ocp_mburstlength;
  logic        ocp_scmdaccept;
`ifdef RX_OCP_XLATE_ERR_EN
  logic        xlate_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0]  b_ctl  [4];
  logic [63:0] b_dat  [4];
  logic [7:0]  b_keep [4];
  logic        b_last [4];
  logic [63:0] e_addr [4];
  logic [31:0] e_data [4];
  logic [3:0]  e_be   [4];

  int   got;
  logic saw_low;

  rx_ocp_xlate #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .ADDR_WIDTH(64)) dut (
    .rx_clk           (clk),
    .rx_reset         (rx_reset),
    .rx_data          (rx_data),
    .rx_keep          (rx_keep),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_last          (rx_last),
    .ocp_reg_ctl      (ocp_reg_ctl),
    .optype           (optype),
    .ocp_ready        (ocp_ready),
    .ocp_mcmd         (ocp_mcmd),
    .ocp_maddr        (ocp_maddr),
    .ocp_mdata        (ocp_mdata),
    .ocp_mbyteen      (ocp_mbyteen),
    .ocp_mburstlength (ocp_mburstlength),
    .ocp_scmdaccept   (ocp_scmdaccept)
`ifdef RX_OCP_XLATE_ERR_EN
    ,
    .xlate_err        (xlate_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_h1(input logic [1:0] fmt, input logic [4:0] typ,
                                        input logic [9:0] len, input logic [3:0] fbe,
                                        input logic [3:0] lbe);
    return {24'h0, lbe, fbe, 1'b0, fmt, typ, 14'h0, len};
  endfunction

  task automatic idle_inputs();
    rx_valid    = 1'b0;
    rx_ready    = 1'b0;
    rx_last     = 1'b0;
    rx_keep     = 8'h00;
    ocp_reg_ctl = CTL_IDLE;
  endtask

  task automatic send(input logic [2:0] ctl, input logic [63:0] d, input logic [7:0] k,
                      input logic l);
    rx_valid    = 1'b1;
    rx_ready    = 1'b1;
    ocp_reg_ctl = ctl;
    rx_data     = d;
    rx_keep     = k;
    rx_last     = l;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic set_beat(input int i, input logic [2:0] ctl, input logic [63:0] d,
                          input logic [7:0] k, input logic l);
    b_ctl[i] = ctl; b_dat[i] = d; b_keep[i] = k; b_last[i] = l;
  endtask

  task automatic set_exp(input int i, input logic [63:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    e_addr[i] = a; e_data[i] = d; e_be[i] = be;
  endtask

  // Acts as Rx FSM (data beats only while ocp_ready) and OCP slave (accept
  // except during the stall window), checking every accepted WR in order.
  task automatic stream(input string tag, input int n_beats, input int n_exp,
                        input int stall_start, input int stall_len,
                        output int n_got, output logic low);
    int   bi = 0;
    logic sent;
    logic acc;
    n_got = 0;
    low   = 1'b0;
    for (int cyc = 0; (cyc < 200) && (n_got < n_exp); cyc++) begin
      sent = 1'b0;
      if ((bi < n_beats) && ocp_ready) begin
        rx_valid = 1'b1; rx_ready = 1'b1; ocp_reg_ctl = b_ctl[bi];
        rx_data = b_dat[bi]; rx_keep = b_keep[bi]; rx_last = b_last[bi];
        sent = 1'b1;
      end else begin
        idle_inputs();
      end
      if ((bi < n_beats) && !ocp_ready) low = 1'b1;
      acc = !((cyc >= stall_start) && (cyc < stall_start + stall_len));
      ocp_scmdaccept = acc;
      if (acc && (ocp_mcmd == MCMD_WR)) begin
        chk($sformatf("%s_addr%0d", tag, n_got), ocp_maddr, e_addr[n_got]);
        chk($sformatf("%s_data%0d", tag, n_got), 64'(ocp_mdata), 64'(e_data[n_got]));
        chk($sformatf("%s_be%0d", tag, n_got), 64'(ocp_mbyteen), 64'(e_be[n_got]));
        n_got++;
      end
      @(posedge clk); #1;
      if (sent) bi++;
    end
    idle_inputs();
    ocp_scmdaccept = 1'b0;
  endtask

  initial begin
    rx_reset = 1'b1;
    rx_data = '0;
    ocp_scmdaccept = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_optype", 64'(optype), 64'h0);
    chk("rst_ready", 64'(ocp_ready), 64'h0);
    chk("rst_mcmd", 64'(ocp_mcmd), 64'(MCMD_IDLE));
    chk("rst_maddr", ocp_maddr, 64'h0);
    chk("rst_mdata", 64'(ocp_mdata), 64'h0);
    chk("rst_be", 64'(ocp_mbyteen), 64'h0);
    chk("rst_burst", 64'(ocp_mburstlength), 64'h0);
`ifdef RX_OCP_XLATE_ERR_EN
    chk("rst_err", 64'(xlate_err), 64'h0);
`endif
    rx_reset = 1'b0;
    @(posedge clk); #1;

    // MRd 3DW, length 4 at 0x1000, held three cycles before accept.
    send(CTL_H1, mk_h1(2'b00, 5'h00, 10'd4, 4'hF, 4'hF), 8'hFF, 1'b0);
    chk("rd1_optype", 64'(optype), 64'h0);
    send(CTL_H2, {32'h0, 32'h0000_1000}, 8'h0F, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rd1_mcmd_c%0d", c), 64'(ocp_mcmd), 64'(MCMD_RD));
      chk($sformatf("rd1_maddr_c%0d", c), ocp_maddr, 64'h1000);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("rd1_burst", 64'(ocp_mburstlength), 64'd4);
    chk("rd1_be", 64'(ocp_mbyteen), 64'hF);
    ocp_scmdaccept = 1'b1;
    @(posedge clk); #1;
    ocp_scmdaccept = 1'b0;
    chk("rd1_idle", 64'(ocp_mcmd), 64'(MCMD_IDLE));

    // MWr 3DW, length 1, data in H2 upper half.
    send(CTL_H1, mk_h1(2'b10, 5'h00, 10'd1, 4'h3, 4'h0), 8'hFF, 1'b0);
    chk("wr1_optype", 64'(optype), 64'h2);
    send(CTL_H2, {32'hDEAD_BEEF, 32'h0000_2004}, 8'hFF, 1'b1);
    chk("wr1_ready", 64'(ocp_ready), 64'h1);
    set_exp(0, 64'h2004, 32'hDEAD_BEEF, 4'h3);
    stream("wr1", 0, 1, 0, 0, got, saw_low);
    chk("wr1_done", 64'(got), 64'd1);
    chk("wr1_idle", 64'(ocp_mcmd), 64'(MCMD_IDLE));
    chk("wr1_ready_off", 64'(ocp_ready), 64'h0);

    // MWr 4DW, length 3; last beat carries one excess DW that must be dropped.
    send(CTL_H1, mk_h1(2'b11, 5'h00, 10'd3, 4'hF, 4'h1), 8'hFF, 1'b0);
    chk("wr3_optype", 64'(optype), 64'h3);
    send(CTL_H2, {32'h0000_0010, 32'h0000_0001}, 8'hFF, 1'b0);
    set_beat(0, CTL_DATA4, {32'hA1A1_A1A1, 32'hA0A0_A0A0}, 8'hFF, 1'b0);
    set_beat(1, CTL_DATA4, {32'hEEEE_EEEE, 32'hA2A2_A2A2}, 8'hFF, 1'b1);
    set_exp(0, 64'h1_0000_0010, 32'hA0A0_A0A0, 4'hF);
    set_exp(1, 64'h1_0000_0014, 32'hA1A1_A1A1, 4'hF);
    set_exp(2, 64'h1_0000_0018, 32'hA2A2_A2A2, 4'h1);
    stream("wr3", 2, 3, 0, 0, got, saw_low);
    chk("wr3_done", 64'(got), 64'd3);
    chk("wr3_ready_low", 64'(saw_low), 64'h1);
    chk("wr3_idle", 64'(ocp_mcmd), 64'(MCMD_IDLE));

    // MWr 3DW, length 4, slave stalls 5 cycles with a full buffer.
    send(CTL_H1, mk_h1(2'b10, 5'h00, 10'd4, 4'hC, 4'h7), 8'hFF, 1'b0);
    send(CTL_H2, {32'hB0B0_B0B0, 32'h0000_3000}, 8'hFF, 1'b0);
    set_beat(0, CTL_DATA3, {32'hB2B2_B2B2, 32'hB1B1_B1B1}, 8'hFF, 1'b0);
    set_beat(1, CTL_DATA3, {32'h0, 32'hB3B3_B3B3}, 8'h0F, 1'b1);
    set_exp(0, 64'h3000, 32'hB0B0_B0B0, 4'hC);
    set_exp(1, 64'h3004, 32'hB1B1_B1B1, 4'hF);
    set_exp(2, 64'h3008, 32'hB2B2_B2B2, 4'hF);
    set_exp(3, 64'h300C, 32'hB3B3_B3B3, 4'h7);
    stream("wr4", 2, 4, 0, 5, got, saw_low);
    chk("wr4_done", 64'(got), 64'd4);
    chk("wr4_ready_low", 64'(saw_low), 64'h1);
    chk("wr4_idle", 64'(ocp_mcmd), 64'(MCMD_IDLE));

    // Reset while the second WR of a length-4 write is pending.
    send(CTL_H1, mk_h1(2'b10, 5'h00, 10'd4, 4'hF, 4'hF), 8'hFF, 1'b0);
    send(CTL_H2, {32'hC0C0_C0C0, 32'h0000_4000}, 8'hFF, 1'b0);
    set_beat(0, CTL_DATA3, {32'hC2C2_C2C2, 32'hC1C1_C1C1}, 8'hFF, 1'b0);
    set_beat(1, CTL_DATA3, {32'h0, 32'hC3C3_C3C3}, 8'h0F, 1'b1);
    set_exp(0, 64'h4000, 32'hC0C0_C0C0, 4'hF);
    stream("rst", 2, 1, 0, 0, got, saw_low);
    chk("rst_2nd_mcmd", 64'(ocp_mcmd), 64'(MCMD_WR));
    chk("rst_2nd_data", 64'(ocp_mdata), 64'hC1C1_C1C1);
    chk("rst_2nd_addr", ocp_maddr, 64'h4004);
    rx_reset = 1'b1;
    @(posedge clk); #1;
    rx_reset = 1'b0;
    chk("rst_mid_mcmd", 64'(ocp_mcmd), 64'(MCMD_IDLE));
    chk("rst_mid_ready", 64'(ocp_ready), 64'h0);
    chk("rst_mid_optype", 64'(optype), 64'h0);
    @(posedge clk); #1;
    chk("rst_mid_stay", 64'(ocp_mcmd), 64'(MCMD_IDLE));

    // MRd 4DW after reset, length field 0 (1024 DWs), 64-bit address.
    send(CTL_H1, mk_h1(2'b01, 5'h00, 10'd0, 4'hF, 4'hF), 8'hFF, 1'b0);
    chk("rd2_optype", 64'(optype), 64'h1);
    send(CTL_H2, {32'h2345_6780, 32'h0000_0001}, 8'hFF, 1'b1);
    chk("rd2_mcmd", 64'(ocp_mcmd), 64'(MCMD_RD));
    chk("rd2_maddr", ocp_maddr, 64'h1_2345_6780);
    chk("rd2_burst", 64'(ocp_mburstlength), 64'd1024);
    chk("rd2_be", 64'(ocp_mbyteen), 64'hF);
    ocp_scmdaccept = 1'b1;
    @(posedge clk); #1;
    ocp_scmdaccept = 1'b0;
    chk("rd2_idle", 64'(ocp_mcmd), 64'(MCMD_IDLE));

`ifdef RX_OCP_XLATE_ERR_EN
    // IO write: flagged, drained, no OCP command; next MRd still works.
    ocp_scmdaccept = 1'b1;
    send(CTL_H1, mk_h1(2'b10, 5'b00010, 10'd1, 4'hF, 4'h0), 8'hFF, 1'b0);
    chk("err_flag", 64'(xlate_err), 64'h1);
    chk("err_h1_mcmd", 64'(ocp_mcmd), 64'(MCMD_IDLE));
    send(CTL_H2, {32'h1111_1111, 32'h0000_5000}, 8'hFF, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("err_mcmd_c%0d", c), 64'(ocp_mcmd), 64'(MCMD_IDLE));
      @(posedge clk); #1;
    end
    ocp_scmdaccept = 1'b0;
    send(CTL_H1, mk_h1(2'b00, 5'h00, 10'd2, 4'hF, 4'hF), 8'hFF, 1'b0);
    send(CTL_H2, {32'h0, 32'h0000_6000}, 8'h0F, 1'b1);
    chk("err_rd_mcmd", 64'(ocp_mcmd), 64'(MCMD_RD));
    chk("err_rd_maddr", ocp_maddr, 64'h6000);
    chk("err_sticky", 64'(xlate_err), 64'h1);
    ocp_scmdaccept = 1'b1;
    @(posedge clk); #1;
    ocp_scmdaccept = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
